dtm_dmi_dr: RTL and testbench

// - DMI and DTMCS data-register stage of the JTAG debug transport, downstream of the TAP controller.
// - Captures, shifts and updates the 32-bit DTMCS and (ABITS+34)-bit DMI registers from the TAP state.
// - Converts DMI Update-DR scans into single-outstanding valid/ready requests to the debug module.
// - Returns debug-module responses to the host on the next Capture-DR.
// - Runs entirely in the tclk domain.

---
 rtl/dtm_dmi_dr.sv | 131 +++++++++++++
 tb/tb_dtm_dmi_dr.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtm_dmi_dr.sv
// dtm_dmi_dr: JTAG DTMCS/DMI data-register stage bridging Update-DR scans to a single-outstanding DMI request port
package jtag;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR,
        SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR,
        EXIT2_IR, UPDATE_IR
    } jtag_state_t;
endpackage

module dtm_dmi_dr #(
    parameter int ABITS       = 7,
    parameter int IDLE_CYCLES = 1
) (
    input  logic               tclk,
    input  logic               trst,
    input  jtag::jtag_state_t  state,
    input  logic               ir_dmi,
    input  logic               ir_dtmcs,
    input  logic               tdi,
    output logic               dr_tdo,
    output logic               dmi_req_valid,
    input  logic               dmi_req_ready,
    output logic [ABITS-1:0]   dmi_req_addr,
    output logic [31:0]        dmi_req_data,
    output logic [1:0]         dmi_req_op,
    input  logic               dmi_resp_valid,
    output logic               dmi_resp_ready,
    input  logic [31:0]        dmi_resp_data,
    input  logic [1:0]         dmi_resp_op
);
    localparam int W = ABITS + 34;
    localparam int N = (W > 32) ? W : 32;
    localparam logic [5:0] ABITS_F = 6'(ABITS);
    localparam logic [2:0] IDLE_F  = 3'(IDLE_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} fsm_t;

    fsm_t             fsm;
    logic [N-1:0]     shift_q;
    logic [ABITS-1:0] addr_q;
    logic [31:0]      data_q;
    logic [1:0]       err_q;
    logic [N-1:0]     cap_dtm, cap_dmi, sh_dtm, sh_dmi;
    logic [1:0]       opstat;
    logic             is_cap, is_upd, busy, dmi_go;

    assign dr_tdo         = shift_q[0];
    assign dmi_resp_ready = 1'b1;
    assign is_cap         = state == jtag::CAPTURE_DR;
    assign is_upd         = state == jtag::UPDATE_DR;
    assign busy           = fsm != IDLE;
    assign opstat         = (err_q != 2'd0) ? err_q : (busy ? 2'd3 : 2'd0);
    assign dmi_go         = ir_dmi && is_upd && (shift_q[1:0] == 2'd1 || shift_q[1:0] == 2'd2) && err_q == 2'd0;

    // capture images and one-bit shift images for both registers
    always_comb begin
        cap_dtm        = '0;
        cap_dtm[31:0]  = {14'b0, 2'b0, 1'b0, IDLE_F, err_q, ABITS_F, 4'd1};
        cap_dmi        = '0;
        cap_dmi[W-1:0] = {addr_q, data_q, opstat};
        sh_dtm         = shift_q >> 1;
        sh_dtm[31]     = tdi;
        sh_dmi         = shift_q >> 1;
        sh_dmi[W-1]    = tdi;
    end

    // shift register: capture on Capture-DR, shift toward tdo on Shift-DR
    always_ff @(posedge tclk or negedge trst) begin
        if (!trst)
            shift_q <= '0;
        else if (state == jtag::TEST_LOGIC_RESET)
            shift_q <= '0;
        else if (ir_dmi || ir_dtmcs) begin
            if (is_cap)
                shift_q <= ir_dtmcs ? cap_dtm : cap_dmi;
            else if (state == jtag::SHIFT_DR)
                shift_q <= ir_dtmcs ? sh_dtm : sh_dmi;
        end
    end

    // request/response FSM, sticky error and the registered request payload
    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            fsm           <= IDLE;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            err_q         <= '0;
        end else if (state == jtag::TEST_LOGIC_RESET) begin
            fsm           <= IDLE;
            dmi_req_valid <= 1'b0;
            err_q         <= '0;
        end else begin
            case (fsm)
                REQ: if (dmi_req_ready) begin
                    dmi_req_valid <= 1'b0;
                    fsm           <= WAIT;
                end
                WAIT: if (dmi_resp_valid) begin
                    data_q <= dmi_resp_data;
                    fsm    <= IDLE;
                    if (dmi_resp_op == 2'd2 && err_q == 2'd0)
                        err_q <= 2'd2;
                end
                default: ;
            endcase
            if (ir_dmi && is_cap && busy && err_q == 2'd0)
                err_q <= 2'd3;
            if (ir_dtmcs && is_upd && (shift_q[16] || shift_q[17]))
                err_q <= 2'd0;
            if (ir_dtmcs && is_upd && shift_q[17]) begin
                fsm           <= IDLE;
                dmi_req_valid <= 1'b0;
            end
            if (dmi_go && busy)
                err_q <= 2'd3;
            if (dmi_go && !busy) begin
                dmi_req_valid <= 1'b1;
                dmi_req_addr  <= shift_q[W-1:34];
                dmi_req_data  <= shift_q[33:2];
                dmi_req_op    <= shift_q[1:0];
                addr_q        <= shift_q[W-1:34];
                fsm           <= REQ;
            end
        end
    end
endmodule

// File: tb/tb_dtm_dmi_dr.sv
// tb_dtm_dmi_dr: randomized self-checking bench for the DTMCS/DMI data-register stage
module tb_dtm_dmi_dr;
    import jtag::*;

    logic        tclk = 1'b0;
    logic        trst = 1'b0;
    jtag_state_t state = TEST_LOGIC_RESET;
    logic        ir_dmi = 1'b0, ir_dtmcs = 1'b0, tdi = 1'b0;
    logic        dr_tdo;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid = 1'b0;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data = '0;
    logic [1:0]  dmi_resp_op = '0;

    int checks = 0;
    int errors = 0;

    // reference model: error code, outstanding request, captured address and read data
    logic [1:0]  m_err = '0;
    bit          m_out = 1'b0;
    logic [6:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    dtm_dmi_dr #(.ABITS(7), .IDLE_CYCLES(1)) dut (
        .tclk(tclk), .trst(trst), .state(state), .ir_dmi(ir_dmi), .ir_dtmcs(ir_dtmcs),
        .tdi(tdi), .dr_tdo(dr_tdo), .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op)
    );

    always #5 tclk = ~tclk;

    function automatic logic [40:0] m_cap_dmi();
        logic [1:0] st;
        st = (m_err != 0) ? m_err : (m_out ? 2'd3 : 2'd0);
        if (m_out && m_err == 0) m_err = 2'd3;
        return {m_addr, m_data, st};
    endfunction

    function automatic logic [31:0] m_cap_dtmcs();
        return 32'h0000_1071 | (32'(m_err) << 10);
    endfunction

    function automatic bit m_upd_dmi(input logic [40:0] v);
        if (v[1:0] != 2'd1 && v[1:0] != 2'd2) return 1'b0;
        if (m_err != 0) return 1'b0;
        if (m_out) begin m_err = 2'd3; return 1'b0; end
        m_out  = 1'b1;
        m_addr = v[40:34];
        return 1'b1;
    endfunction

    function automatic void m_upd_dtmcs(input logic [31:0] v);
        if (v[16] || v[17]) m_err = 2'd0;
        if (v[17]) m_out = 1'b0;
    endfunction

    function automatic void m_resp(input logic [31:0] d, input logic [1:0] op);
        m_data = d;
        if (op == 2'd2 && m_err == 0) m_err = 2'd2;
        m_out = 1'b0;
    endfunction

    // full Capture/Shift/Update pass; returns the bits seen on dr_tdo
    task automatic scan(input bit dmi, input logic [40:0] din, output logic [40:0] dout);
        int n = dmi ? 41 : 32;
        ir_dmi = dmi; ir_dtmcs = !dmi;
        state = CAPTURE_DR;
        @(negedge tclk);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            state = SHIFT_DR; tdi = din[i]; dout[i] = dr_tdo;
            @(negedge tclk);
        end
        state = EXIT1_DR;
        @(negedge tclk);
        state = UPDATE_DR;
        @(negedge tclk);
        state = RUN_TEST_IDLE;
    endtask

    task automatic accept();
        dmi_req_ready = 1'b1;
        @(negedge tclk);
        dmi_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] op);
        dmi_resp_valid = 1'b1; dmi_resp_data = d; dmi_resp_op = op;
        @(negedge tclk);
        dmi_resp_valid = 1'b0;
        m_resp(d, op);
    endtask

    task automatic test_reset();
        trst = 1'b0;
        repeat (2) @(negedge tclk);
        checks++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dr_tdo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b a=%h d=%h op=%h tdo=%b exp all 0",
                     dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dr_tdo);
        end
        checks++;
        if (dmi_resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready got %b exp 1", dmi_resp_ready); end
        trst = 1'b1;
        state = RUN_TEST_IDLE;
        @(negedge tclk);
    endtask

    task automatic test_dtmcs();
        logic [40:0] dout;
        logic [31:0] exp;
        exp = m_cap_dtmcs();
        scan(1'b0, 41'd0, dout);
        checks++;
        if (dout[31:0] !== exp) begin errors++; $display("FAIL dtmcs_capture got %h exp %h", dout[31:0], exp); end
    endtask

    task automatic test_write_stall();
        logic [40:0] din, dout, exp;
        logic [31:0] r;
        bit go;
        din = {7'h10, 32'h0000_0001, 2'd2};
        exp = m_cap_dmi();
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL write_capture got %h exp %h", dout, exp); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {go, din[40:34], din[33:2], din[1:0]}) begin
                errors++;
                $display("FAIL write_stall cyc %0d got v=%b a=%h d=%h op=%h exp v=1 a=10 d=1 op=2",
                         i, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
            end
            if (i < 5) @(negedge tclk);
        end
        accept();
        checks++;
        if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL write_drop got %b exp 0", dmi_req_valid); end
        r = $urandom;
        respond(r, 2'd0);
        exp = m_cap_dmi();
        scan(1'b1, {7'($urandom), 32'($urandom), 2'd0}, dout);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL write_result got %h exp %h", dout, exp); end
    endtask

    task automatic test_read();
        logic [40:0] din, dout, exp;
        bit go;
        din = {7'h11, 32'($urandom), 2'd1};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        checks++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !== {go, 7'h11, 2'd1}) begin
            errors++;
            $display("FAIL read_req got v=%b a=%h op=%h exp v=1 a=11 op=1", dmi_req_valid, dmi_req_addr, dmi_req_op);
        end
        accept();
        respond(32'hDEAD_BEEF, 2'd0);
        exp = m_cap_dmi();
        scan(1'b1, 41'd0, dout);
        checks++;
        if (dout !== exp || exp !== {7'h11, 32'hDEAD_BEEF, 2'd0}) begin
            errors++; $display("FAIL read_result got %h exp %h", dout, exp);
        end
    endtask

    task automatic test_busy();
        logic [40:0] din, dout, exp;
        logic [31:0] d;
        bit go;
        din = {7'($urandom), 32'($urandom), 2'd1};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        accept();
        din = {7'($urandom), 32'($urandom), 2'd2};
        exp = m_cap_dmi();
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL busy_capture got %h exp %h", dout, exp); end
        checks++;
        if (dmi_req_valid !== go) begin errors++; $display("FAIL busy_noreq got %b exp %b", dmi_req_valid, go); end
        d = $urandom;
        respond(d, 2'd0);
        exp = 41'(m_cap_dtmcs());
        scan(1'b0, 41'h0_0001_0000, dout);
        m_upd_dtmcs(32'h0001_0000);
        checks++;
        if (dout[31:0] !== exp[31:0] || exp[11:10] !== 2'd3) begin
            errors++; $display("FAIL busy_dtmcs got %h exp %h", dout[31:0], exp[31:0]);
        end
        din = {7'($urandom), 32'($urandom), 2'd2};
        exp = m_cap_dmi();
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL cleared_capture got %h exp %h", dout, exp); end
        checks++;
        if (dmi_req_valid !== go || go !== 1'b1) begin errors++; $display("FAIL cleared_req got %b exp 1", dmi_req_valid); end
        accept();
        respond($urandom, 2'd0);
    endtask

    task automatic test_resp_err();
        logic [40:0] din, dout, exp;
        bit go;
        din = {7'($urandom), 32'($urandom), 2'd1};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        accept();
        respond($urandom, 2'd2);
        for (int i = 0; i < 2; i++) begin
            din = {7'($urandom), 32'($urandom), 2'd2};
            exp = m_cap_dmi();
            scan(1'b1, din, dout);
            go = m_upd_dmi(din);
            checks++;
            if (dout !== exp || exp[1:0] !== 2'd2) begin errors++; $display("FAIL err2_capture %0d got %h exp %h", i, dout, exp); end
            checks++;
            if (dmi_req_valid !== go) begin errors++; $display("FAIL err2_noreq got %b exp %b", dmi_req_valid, go); end
        end
        exp = 41'(m_cap_dtmcs());
        scan(1'b0, 41'h0_0001_0000, dout);
        m_upd_dtmcs(32'h0001_0000);
        checks++;
        if (dout[31:0] !== exp[31:0]) begin errors++; $display("FAIL err2_dtmcs got %h exp %h", dout[31:0], exp[31:0]); end
        exp = m_cap_dmi();
        scan(1'b1, 41'd0, dout);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL err2_cleared got %h exp %h", dout, exp); end
    endtask

    task automatic test_hardreset();
        logic [40:0] din, dout, exp;
        bit go;
        din = {7'($urandom), 32'($urandom), 2'd2};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        exp = 41'(m_cap_dtmcs());
        scan(1'b0, 41'h0_0002_0000, dout);
        m_upd_dtmcs(32'h0002_0000);
        checks++;
        if (dout[31:0] !== exp[31:0]) begin errors++; $display("FAIL hard_dtmcs got %h exp %h", dout[31:0], exp[31:0]); end
        checks++;
        if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL hard_drop got %b exp 0", dmi_req_valid); end
        exp = m_cap_dmi();
        scan(1'b1, 41'd0, dout);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL hard_capture got %h exp %h", dout, exp); end
    endtask

    task automatic test_tlr();
        logic [40:0] din, dout, exp;
        bit go;
        din = {7'($urandom), 32'($urandom), 2'd1};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        state = TEST_LOGIC_RESET;
        @(negedge tclk);
        m_err = 2'd0; m_out = 1'b0;
        checks++;
        if ({dmi_req_valid, dr_tdo} !== 2'b00) begin errors++; $display("FAIL tlr_drop got v=%b tdo=%b exp 0 0", dmi_req_valid, dr_tdo); end
        state = RUN_TEST_IDLE;
        @(negedge tclk);
        exp = m_cap_dmi();
        scan(1'b1, 41'd0, dout);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL tlr_capture got %h exp %h", dout, exp); end
    endtask

    task automatic test_trst();
        logic [40:0] din, dout, exp;
        bit go;
        din = {7'($urandom), 32'($urandom), 2'd2};
        void'(m_cap_dmi());
        scan(1'b1, din, dout);
        go = m_upd_dmi(din);
        #2 trst = 1'b0;
        #1;
        checks++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !== '0) begin
            errors++; $display("FAIL trst_drop got v=%b a=%h op=%h exp 0", dmi_req_valid, dmi_req_addr, dmi_req_op);
        end
        @(negedge tclk);
        trst = 1'b1;
        m_err = 2'd0; m_out = 1'b0; m_addr = '0; m_data = '0;
        @(negedge tclk);
        exp = m_cap_dmi();
        scan(1'b1, 41'd0, dout);
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL trst_capture got %h exp %h", dout, exp); end
    endtask

    task automatic test_random();
        logic [40:0] din, dout, exp;
        bit go;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                din = '0;
                din[16] = 1'($urandom);
                exp = 41'(m_cap_dtmcs());
                scan(1'b0, din, dout);
                m_upd_dtmcs(din[31:0]);
                checks++;
                if (dout[31:0] !== exp[31:0]) begin errors++; $display("FAIL rnd_dtmcs %0d got %h exp %h", it, dout[31:0], exp[31:0]); end
            end else begin
                din = {7'($urandom), 32'($urandom), 2'($urandom)};
                exp = m_cap_dmi();
                scan(1'b1, din, dout);
                go = m_upd_dmi(din);
                checks++;
                if (dout !== exp) begin errors++; $display("FAIL rnd_capture %0d got %h exp %h", it, dout, exp); end
                checks++;
                if (dmi_req_valid !== go || (go && {dmi_req_addr, dmi_req_data, dmi_req_op} !== din)) begin
                    errors++;
                    $display("FAIL rnd_req %0d got v=%b %h exp v=%b %h", it, dmi_req_valid,
                             {dmi_req_addr, dmi_req_data, dmi_req_op}, go, din);
                end
                if (go) begin
                    repeat ($urandom_range(0, 3)) @(negedge tclk);
                    accept();
                    checks++;
                    if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop %0d got %b exp 0", it, dmi_req_valid); end
                    repeat ($urandom_range(0, 2)) @(negedge tclk);
                    respond($urandom, ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dtmcs();
        test_write_stall();
        test_read();
        test_busy();
        test_resp_err();
        test_hardreset();
        test_tlr();
        test_trst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
